// File: rtl/seg_pkg.sv
// Shared constants, glyph table and source-select enum for the 7-segment display blocks.
package seg_pkg;

   localparam int DIGIT_W = 4;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low {g,f,e,d,c,b,a} glyphs for hex 0..F (A,b,C,d,E,F).
   localparam logic [6:0] SEG_GLYPHS [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic {
      SRC_IN  = 1'b0,
      SRC_SET = 1'b1
   } src_sel_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble to active-low 7-segment pattern lookup.
module seg7_decode
   import seg_pkg::*;
(
   input  logic [DIGIT_W-1:0] nibble,
   output logic [6:0]         seg_n
);

   // Table lookup; every nibble value has a glyph.
   always_comb begin
      seg_n = SEG_GLYPHS[nibble];
   end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment display of the entered/stored lock code with reveal hold and edit blink.
// Optional: SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits outside edit mode.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS   = 3,
   parameter int SCAN_DIV     = 50000,
   parameter int REVEAL_TICKS = 2000,
   parameter int BLINK_TICKS  = 250
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] pass_in,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] pass_set,
   input  logic                         mode,
   input  logic                         L,
   input  logic                         show,
   input  logic [2:0]                   edit_pos,
   output logic [6:0]                   seg_n,
   output logic [NUM_DIGITS-1:0]        an_n,
   output logic [2:0]                   cur_digit
);

   localparam int PS_W = $clog2(SCAN_DIV);
   localparam int RC_W = (REVEAL_TICKS > 0) ? $clog2(REVEAL_TICKS + 1) : 1;
   localparam int BL_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam int CW   = DIGIT_W * NUM_DIGITS;

   localparam logic [PS_W-1:0] PS_MAX   = PS_W'(SCAN_DIV - 1);
   localparam logic [RC_W-1:0] RC_LOAD  = RC_W'(REVEAL_TICKS);
   localparam logic [BL_W-1:0] BL_MAX   = BL_W'((BLINK_TICKS > 0) ? BLINK_TICKS - 1 : 0);
   localparam logic [2:0]      IDX_LAST = 3'(NUM_DIGITS - 1);

   generate
      if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
         $error("seg_scan_display: NUM_DIGITS must be 1..8");
      end
      if (SCAN_DIV < 2) begin : g_bad_div
         $error("seg_scan_display: SCAN_DIV must be >= 2");
      end
   endgenerate

   logic [PS_W-1:0]    ps_r;
   logic [2:0]         idx_r;
   logic               show_d_r;
   logic [RC_W-1:0]    rcnt_r;
   logic [BL_W-1:0]    bcnt_r;
   logic               phase_r;
   logic [6:0]         seg_n_r;
   logic [NUM_DIGITS-1:0] an_n_r;
   logic [2:0]         cur_digit_r;

   logic               tick_s;
   logic [2:0]         idx_nxt_s;
   logic               reveal_s;
   logic               edit_s;
   logic               blink_act_s;
   src_sel_e           src_s;
   logic [CW-1:0]      code_s;
   logic [DIGIT_W-1:0] nib_s;
   logic [6:0]         glyph_s;
   logic               lz_blank_s;
   logic               blank_s;
   logic [NUM_DIGITS-1:0] an_s;

   assign tick_s      = (ps_r == PS_MAX);
   assign idx_nxt_s   = (idx_r == IDX_LAST) ? 3'd0 : idx_r + 3'd1;
   assign reveal_s    = show | (rcnt_r != {RC_W{1'b0}});
   assign edit_s      = L & mode;
   assign blink_act_s = edit_s & ~reveal_s;

   // Choose which code feeds the display.
   always_comb begin
      src_s = (reveal_s | edit_s) ? SRC_SET : SRC_IN;
      case (src_s)
         SRC_SET: code_s = pass_set;
         SRC_IN:  code_s = pass_in;
         default: code_s = pass_in;
      endcase
   end

   // Pick the nibble and one-cold anode for the digit about to be driven.
   always_comb begin
      nib_s = {DIGIT_W{1'b0}};
      an_s  = {NUM_DIGITS{1'b1}};
      for (int k = 0; k < NUM_DIGITS; k++) begin
         nib_s   = (idx_nxt_s == 3'(k)) ? code_s[DIGIT_W*k +: DIGIT_W] : nib_s;
         an_s[k] = (idx_nxt_s != 3'(k));
      end
   end

`ifdef SEG_LEADING_ZERO_BLANK_EN
   // A digit is a leading zero when it and every more-significant digit are zero.
   always_comb begin
      logic hi_zero_s;
      hi_zero_s = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         hi_zero_s = hi_zero_s &
                     ((3'(k) < idx_nxt_s) | (code_s[DIGIT_W*k +: DIGIT_W] == {DIGIT_W{1'b0}}));
      end
      if (!edit_s && idx_nxt_s != 3'd0) begin
         lz_blank_s = hi_zero_s;
      end else begin
         lz_blank_s = 1'b0;
      end
   end
`else
   assign lz_blank_s = 1'b0;
`endif

   assign blank_s = (blink_act_s & ~phase_r & (edit_pos == idx_nxt_s)) | lz_blank_s;

   seg7_decode u_decode (
      .nibble (nib_s),
      .seg_n  (glyph_s)
   );

   // Scan prescaler.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ps_r <= {PS_W{1'b0}};
      end else if (tick_s) begin
         ps_r <= {PS_W{1'b0}};
      end else begin
         ps_r <= ps_r + PS_W'(1);
      end
   end

   // Reveal hold: reload on the falling edge of show, count down on ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         show_d_r <= 1'b0;
         rcnt_r   <= {RC_W{1'b0}};
      end else begin
         show_d_r <= show;
         if (show_d_r && !show) begin
            rcnt_r <= RC_LOAD;
         end else if (tick_s && rcnt_r != {RC_W{1'b0}}) begin
            rcnt_r <= rcnt_r - RC_W'(1);
         end
      end
   end

   // Blink phase for the edited digit; restarts visible whenever editing stops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt_r  <= {BL_W{1'b0}};
         phase_r <= 1'b1;
      end else if (!blink_act_s) begin
         bcnt_r  <= {BL_W{1'b0}};
         phase_r <= 1'b1;
      end else if (tick_s) begin
         if (bcnt_r == BL_MAX) begin
            bcnt_r  <= {BL_W{1'b0}};
            phase_r <= ~phase_r;
         end else begin
            bcnt_r <= bcnt_r + BL_W'(1);
         end
      end
   end

   // Scan index and registered pin drive; idx resets to the last digit so the first tick shows digit 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_r       <= IDX_LAST;
         seg_n_r     <= SEG_BLANK;
         an_n_r      <= {NUM_DIGITS{1'b1}};
         cur_digit_r <= 3'd0;
      end else if (tick_s) begin
         idx_r       <= idx_nxt_s;
         seg_n_r     <= blank_s ? SEG_BLANK : glyph_s;
         an_n_r      <= an_s;
         cur_digit_r <= idx_nxt_s;
      end
   end

   assign seg_n     = seg_n_r;
   assign an_n      = an_n_r;
   assign cur_digit = cur_digit_r;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: directed scenarios plus randomized ticks against a tick-level model.
module tb_seg_scan_display;

   localparam int ND     = 3;
   localparam int SDIV   = 4;
   localparam int REVEAL = 5;
   localparam int BLINK  = 2;

   localparam logic [6:0] GLYPH [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   logic            clk = 1'b0;
   logic            rst_n;
   logic [4*ND-1:0] pass_in;
   logic [4*ND-1:0] pass_set;
   logic            mode;
   logic            L;
   logic            show;
   logic [2:0]      edit_pos;
   logic [6:0]      seg_n;
   logic [ND-1:0]   an_n;
   logic [2:0]      cur_digit;

   int test_cnt = 0;
   int fail_cnt = 0;

   // Model state, all in units of scan ticks.
   int m_ticks;
   bit m_fell;
   int m_since_fall;
   int m_edit_ticks;

   seg_scan_display #(
      .NUM_DIGITS   (ND),
      .SCAN_DIV     (SDIV),
      .REVEAL_TICKS (REVEAL),
      .BLINK_TICKS  (BLINK)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .pass_in   (pass_in),
      .pass_set  (pass_set),
      .mode      (mode),
      .L         (L),
      .show      (show),
      .edit_pos  (edit_pos),
      .seg_n     (seg_n),
      .an_n      (an_n),
      .cur_digit (cur_digit)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_ticks      = 0;
      m_fell       = 1'b0;
      m_since_fall = 0;
      m_edit_ticks = 0;
   endtask

   task automatic set_show(input bit v);
      if (show && !v) begin
         m_fell       = 1'b1;
         m_since_fall = 0;
      end
      show = v;
   endtask

   task automatic check_blank(input string tag);
      test_cnt++;
      assert (seg_n === 7'h7F) else begin
         fail_cnt++;
         $error("FAIL %s seg_n: got %h want 7f", tag, seg_n);
      end
      test_cnt++;
      assert (an_n === {ND{1'b1}}) else begin
         fail_cnt++;
         $error("FAIL %s an_n: got %b want %b", tag, an_n, {ND{1'b1}});
      end
      test_cnt++;
      assert (cur_digit === 3'd0) else begin
         fail_cnt++;
         $error("FAIL %s cur_digit: got %0d want 0", tag, cur_digit);
      end
   endtask

   // Wait one scan period, then compare the freshly driven digit with the model.
   task automatic tick_check(input string tag);
      int         digit;
      bit         rev, act, blank;
      logic [4*ND-1:0] src;
      logic [3:0] nib;
      logic [6:0] eseg;
      logic [ND-1:0] ean;
      repeat (SDIV) @(posedge clk);
      #1;
      digit = m_ticks % ND;
      rev   = show || (m_fell && m_since_fall < REVEAL);
      src   = (rev || (L && mode)) ? pass_set : pass_in;
      nib   = src[4*digit +: 4];
      act   = L && mode && !rev;
      blank = act && (((m_edit_ticks / BLINK) % 2) == 1) && (int'(edit_pos) == digit);
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if (!(L && mode) && digit != 0 && (src >> (4*digit)) == 0) blank = 1'b1;
`endif
      eseg = blank ? 7'h7F : GLYPH[nib];
      ean  = ~(ND'(1) << digit);
      test_cnt++;
      assert (seg_n === eseg) else begin
         fail_cnt++;
         $error("FAIL %s seg_n tick %0d: got %h want %h", tag, m_ticks, seg_n, eseg);
      end
      test_cnt++;
      assert (an_n === ean) else begin
         fail_cnt++;
         $error("FAIL %s an_n tick %0d: got %b want %b", tag, m_ticks, an_n, ean);
      end
      test_cnt++;
      assert (cur_digit === 3'(digit)) else begin
         fail_cnt++;
         $error("FAIL %s cur_digit tick %0d: got %0d want %0d", tag, m_ticks, cur_digit, digit);
      end
      m_edit_ticks = act ? m_edit_ticks + 1 : 0;
      if (m_fell) m_since_fall++;
      m_ticks++;
   endtask

   initial begin
      rst_n    = 1'b0;
      pass_in  = 12'h123;
      pass_set = 12'h000;
      mode     = 1'b0;
      L        = 1'b0;
      show     = 1'b0;
      edit_pos = 3'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_blank("reset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (SDIV - 1) @(posedge clk);
      #1;
      check_blank("pre_first_tick");
      repeat (SDIV - 1) @(negedge clk);
      // Realign to the tick edge: first tick is the SDIV-th edge after release.
      m_ticks = 0;

      // Plain scan of the entered code.
      @(posedge clk);
      #1;
      begin
         test_cnt++;
         assert (an_n === 3'b110 && seg_n === 7'h30) else begin
            fail_cnt++;
            $error("FAIL first_tick: got an_n=%b seg_n=%h want 110/30", an_n, seg_n);
         end
         m_ticks = 1;
      end
      for (int i = 0; i < 6; i++) tick_check("scan_123");

      // Edit mode blink on digit 1.
      L = 1'b1; mode = 1'b1; pass_set = 12'h9A0; edit_pos = 3'd1;
      for (int i = 0; i < 12; i++) tick_check("blink");

      // Reveal hold after show falls.
      L = 1'b0; mode = 1'b0; pass_in = 12'h111; pass_set = 12'h222;
      set_show(1'b1);
      for (int i = 0; i < 10; i++) tick_check("reveal_high");
      set_show(1'b0);
      for (int i = 0; i < 8; i++) tick_check("reveal_hold");

      // Out-of-range edit position never blanks.
      L = 1'b1; mode = 1'b1; edit_pos = 3'd5; pass_set = 12'h456;
      for (int i = 0; i < 9; i++) tick_check("edit_pos5");

      // Leading zeros.
      L = 1'b0; mode = 1'b0; pass_in = 12'h007;
      for (int i = 0; i < 3; i++) tick_check("lead_zero");

      // Reset mid-scan right after digit 2 was driven.
      while ((m_ticks % ND) != 0) tick_check("to_idx2");
      rst_n = 1'b0;
      #1;
      check_blank("mid_reset");
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      tick_check("after_reset");

      // Randomized inputs, changed just after each tick.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) L = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 9) == 0) set_show(~show);
         if ($urandom_range(0, 15) == 0) edit_pos = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) pass_in = 12'($urandom) & ($urandom_range(0, 1) ? 12'hFFF : 12'h0FF);
         if ($urandom_range(0, 3) == 0) pass_set = 12'($urandom) & ($urandom_range(0, 1) ? 12'hFFF : 12'h00F);
         tick_check("random");
      end

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Parametrised successor to the 3-digit password display mux in the digital lock.
- Selects the entered code or the stored code per the lock mode, holds a timed "reveal" after `show` is released, and blinks the digit under edit in set mode.
- Time-multiplexes NUM_DIGITS digits onto one shared active-low 7-segment bus with active-low anode enables.
- Sits between the lock FSM/keypad registers and the board's 7-segment pins.

Parameters:
- NUM_DIGITS, 3, number of 4-bit digits displayed (1..8).
- SCAN_DIV, 50000, clk cycles per scan tick (>=2).
- REVEAL_TICKS, 2000, scan ticks that `pass_set` stays shown after `show` falls.
- BLINK_TICKS, 250, scan ticks per blink half-period.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- pass_in  in  4*NUM_DIGITS  entered code; digit k = bits [4k+3:4k], digit 0 rightmost.
- pass_set  in  4*NUM_DIGITS  stored code, same packing.
- mode  in  1  1 = set-password mode.
- L  in  1  1 = lock in locked/edit state.
- show  in  1  level; request to display the stored code.
- edit_pos  in  3  index of the digit being edited.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active low.
- an_n  out  NUM_DIGITS  digit enables, active low, one-cold.
- cur_digit  out  3  index of the digit currently driven.

Behaviour:
- Reset:
  - Asynchronous, active-low. While rst_n=0: seg_n=7'h7F, an_n=all 1, cur_digit=0.
  - Prescaler=0, reveal counter=0, blink phase=1 (visible), blink counter=0.
  - Outputs stay blank until the first scan tick after release.
- Prescaler:
  - Counts 0..SCAN_DIV-1; tick is asserted for one cycle when count = SCAN_DIV-1, and the count wraps to 0.
- Scan index:
  - On tick, idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1.
  - All outputs are registered and update in the cycle after the tick, using the new idx.
  - Exactly one an_n bit is low at any time after the first tick.
- Reveal:
  - reveal = show | (rcnt != 0).
  - On the falling edge of show (registered show_d=1, show=0), rcnt <= REVEAL_TICKS.
  - Otherwise rcnt decrements on each tick while nonzero.
  - A new rising edge of show during the hold keeps reveal high; the next falling edge reloads rcnt.
- Source select, per tick:
  - reveal=1: pass_set.
  - L=1 and mode=1: pass_set.
  - Otherwise: pass_in.
  - Inputs are sampled at the tick; changes between ticks are not visible until the next tick.
- Decode:
  - Nibbles 0-F map to hex glyphs; A-F render as A,b,C,d,E,F.
- Blink:
  - Active only when L=1, mode=1 and reveal=0.
  - Blink counter counts ticks; on reaching BLINK_TICKS-1 it clears and the phase toggles.
  - When the phase is 0 and idx==edit_pos, seg_n=7'h7F while an_n still selects that digit.
  - edit_pos >= NUM_DIGITS: never blanks.
  - Leaving edit conditions forces phase=1 and counter=0.
- Width rule: `pass_*` widths must equal 4*NUM_DIGITS; mismatch is an elaboration error.

Optional Feature:
- Macro SEG_LEADING_ZERO_BLANK_EN.
- When defined: leading zero digits (most-significant side) render blank while not in edit mode. Digit 0 is always shown.
- When undefined: all digits render, zeros included.

Decomposition:
- Package seg_pkg:
  - DIGIT_W=4.
  - SEG_BLANK=7'h7F.
  - 16-entry active-low glyph table.
  - enum src_sel_e {SRC_IN, SRC_SET}.
- Sub-module seg7_decode: combinational nibble-to-seg_n lookup, reused by other display blocks.

Test Plan:
1. NUM_DIGITS=3, SCAN_DIV=4, pass_in=12'h123, L=0, show=0 -> an_n cycles 110,101,011 every 4 clk; seg_n = glyphs 3,2,1 (7'h30,7'h24,7'h79).
2. L=1, mode=1, pass_set=12'h9A0, BLINK_TICKS=2, edit_pos=1 -> digits show 0,A,9, except digit 1 is blank on alternating 2-tick phases.
3. show pulsed high for 10 ticks, then low, REVEAL_TICKS=5, pass_in=12'h111, pass_set=12'h222 -> "2" shown for 10 ticks plus 5 ticks, then "1" from the next tick.
4. rst_n asserted mid-scan with idx=2 -> same cycle seg_n=7F, an_n=111; after release, first tick drives digit 0 (cur_digit=0).
5. edit_pos=5, NUM_DIGITS=3, edit mode -> no digit ever blanks.
6. With SEG_LEADING_ZERO_BLANK_EN, pass_in=12'h007 -> digits 2 and 1 blank, digit 0 shows 7 (7'h78). Without the macro -> 0,0,7 shown.
